// File: rtl/wma_sample_source_if.sv
// Upstream valid/ready sample port feeding the WMA sample source FIFO.
interface wma_sample_source_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/wma_sample_source.sv
// Circular-FIFO sample source driving the WMA filter x input at one sample
// per clock, with priming, underrun zero-padding and start/stop control.
module wma_sample_source #(
    parameter int N     = 8,
    parameter int DEPTH = 16,
    parameter int PRIME = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    wma_sample_source_if.slave  up,
    input  logic                start,
    input  logic                stop,
    output logic [N-1:0]        x,
    output logic                x_valid,
    output logic                underrun,
    output logic [CW-1:0]       count,
    output logic                busy
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [N-1:0]    x_reg;
    logic            x_valid_reg, underrun_reg;
    logic            push, pop, empty, clear_underrun;

    assign empty       = (count_reg == '0);
    assign up.in_ready = (count_reg != CW'(DEPTH));
    assign push        = up.in_valid && up.in_ready;
    // stop wins over the pop on the same cycle so the last pop precedes stop
    assign pop         = (state_reg == S_RUN) && !stop && !empty;

    always_comb begin
        state_next     = state_reg;
        clear_underrun = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!stop && start) begin
                    state_next     = S_PRIME;
                    clear_underrun = 1'b1;
                end
            end
            S_PRIME: begin
                if (stop)
                    state_next = S_IDLE;
                else if (count_reg >= CW'(PRIME))
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (stop)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= up.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // x is forced to zero whenever no sample is popped, so the filter
    // only ever sees real samples or zero padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg        <= '0;
            x_valid_reg  <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (pop) begin
                x_reg       <= mem[rd_ptr_reg];
                x_valid_reg <= 1'b1;
            end else begin
                x_reg       <= '0;
                x_valid_reg <= 1'b0;
            end
            if (clear_underrun)
                underrun_reg <= 1'b0;
            else if (state_reg == S_RUN && !stop && empty)
                underrun_reg <= 1'b1;
        end
    end

    assign x        = x_reg;
    assign x_valid  = x_valid_reg;
    assign underrun = underrun_reg;
    assign count    = count_reg;
    assign busy     = (state_reg != S_IDLE);
endmodule
